// File: rtl/obstacle_detector_array.sv
// rtl/obstacle_detector_array.sv - multi-channel debounced obstacle detector with escalating buzz levels
module obstacle_detector_array #(
   parameter int NUM_CH   = 4,
   parameter int DEBOUNCE = 4,
   parameter int ESC_STEP = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [NUM_CH-1:0]     sensor,
   output logic [2*NUM_CH-1:0]   buzz_level,
   output logic                  any_alert,
   output logic                  alert_pulse
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int DW_W = $clog2(2 * ESC_STEP + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
   localparam logic [DW_W-1:0] DW_STEP = DW_W'(ESC_STEP);
   localparam logic [DW_W-1:0] DW_MAX  = DW_W'(2 * ESC_STEP);

   logic [NUM_CH-1:0] sync_a;
   logic [NUM_CH-1:0] sync_b;
   logic [NUM_CH-1:0] lvl_hi;
   logic [NUM_CH-1:0] lvl_3;
   logic              l3_any;
   logic              l3_q;

   // Synchroniser ignores en so a re-enabled channel sees a settled input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= sensor;
         sync_b <= sync_a;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic            stable;
      logic [DB_W-1:0] db_cnt;
      logic [DW_W-1:0] dwell;
      logic [1:0]      level;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
         end else if (!en) begin
            stable <= 1'b0;
            db_cnt <= '0;
         end else if (sync_b[i] == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end

      // Dwell is zero whenever stable is low, so the rising edge starts from 0
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dwell <= '0;
         end else if (!en || !stable) begin
            dwell <= '0;
         end else if (dwell != DW_MAX) begin
            dwell <= dwell + DW_W'(1);
         end
      end

      always_comb begin
         level = 2'd0;
         if (!stable)
            level = 2'd0;
         else if (dwell < DW_STEP)
            level = 2'd1;
         else if (dwell < DW_MAX)
            level = 2'd2;
         else
            level = 2'd3;
      end

      assign buzz_level[2*i +: 2] = level;
      assign lvl_hi[i]            = level[1];
      assign lvl_3[i]             = (level == 2'd3);
   end

   assign any_alert = |lvl_hi;
   assign l3_any    = |lvl_3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         l3_q <= 1'b0;
      else if (!en)
         l3_q <= 1'b0;
      else
         l3_q <= l3_any;
   end

   assign alert_pulse = l3_any & ~l3_q;

endmodule

// File: tb/tb_obstacle_detector_array.sv
// tb/tb_obstacle_detector_array.sv - directed self-checking bench for obstacle_detector_array
module tb_obstacle_detector_array;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] sensor;
   logic [7:0] buzz_level;
   logic       any_alert;
   logic       alert_pulse;

   int tests;
   int fails;

   obstacle_detector_array #(
      .NUM_CH   (4),
      .DEBOUNCE (4),
      .ESC_STEP (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .sensor      (sensor),
      .buzz_level  (buzz_level),
      .any_alert   (any_alert),
      .alert_pulse (alert_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [1:0] lv(input int ch);
      return buzz_level[2*ch +: 2];
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b1; sensor = 4'b0000;
      tick(2);
      tests++;
      if ({buzz_level, any_alert, alert_pulse} !== 10'b0) begin
         fails++; $display("FAIL reset_initial: got %b, want 0", {buzz_level, any_alert, alert_pulse});
      end
      rst_n = 1'b1;
      tick(1);
      sensor[0] = 1'b1;
      tick(22);
      tests++;
      if (lv(0) !== 2'd3) begin
         fails++; $display("FAIL reset_precond_l3: got %0d, want 3", lv(0));
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({buzz_level, any_alert, alert_pulse} !== 10'b0) begin
         fails++; $display("FAIL reset_async: got %b, want 0", {buzz_level, any_alert, alert_pulse});
      end
      sensor = 4'b0000;
      tick(2);
      #2 rst_n = 1'b1;
      tick(10);
      tests++;
      if ({buzz_level, any_alert, alert_pulse} !== 10'b0) begin
         fails++; $display("FAIL reset_idle: got %b, want 0", {buzz_level, any_alert, alert_pulse});
      end
   endtask

   task automatic test_debounce;
      sensor[1] = 1'b1;
      tick(3);
      sensor[1] = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick(1);
         tests++;
         if (lv(1) !== 2'd0) begin
            fails++; $display("FAIL debounce_short t=%0d: got %0d, want 0", t, lv(1));
         end
      end
      sensor[1] = 1'b1;
      tick(5);
      tests++;
      if (lv(1) !== 2'd0) begin
         fails++; $display("FAIL latency_early: got %0d, want 0", lv(1));
      end
      tick(1);
      tests++;
      if (lv(1) !== 2'd1) begin
         fails++; $display("FAIL latency_rise: got %0d, want 1", lv(1));
      end
   endtask

   task automatic test_escalation;
      tick(7);
      tests++;
      if (lv(1) !== 2'd1 || any_alert !== 1'b0) begin
         fails++; $display("FAIL esc_l1_hold: got lvl %0d alert %b, want 1 0", lv(1), any_alert);
      end
      tick(1);
      tests++;
      if (lv(1) !== 2'd2 || any_alert !== 1'b1) begin
         fails++; $display("FAIL esc_l2: got lvl %0d alert %b, want 2 1", lv(1), any_alert);
      end
      tick(7);
      tests++;
      if (lv(1) !== 2'd2 || alert_pulse !== 1'b0) begin
         fails++; $display("FAIL esc_l2_hold: got lvl %0d pulse %b, want 2 0", lv(1), alert_pulse);
      end
      tick(1);
      tests++;
      if (lv(1) !== 2'd3 || alert_pulse !== 1'b1) begin
         fails++; $display("FAIL esc_l3_pulse: got lvl %0d pulse %b, want 3 1", lv(1), alert_pulse);
      end
      tick(1);
      tests++;
      if (alert_pulse !== 1'b0) begin
         fails++; $display("FAIL esc_pulse_width: got %b, want 0", alert_pulse);
      end
      tick(100);
      tests++;
      if (lv(1) !== 2'd3 || any_alert !== 1'b1 || alert_pulse !== 1'b0) begin
         fails++; $display("FAIL esc_saturate: got lvl %0d alert %b pulse %b, want 3 1 0", lv(1), any_alert, alert_pulse);
      end
   endtask

   task automatic test_release_glitch;
      sensor[1] = 1'b0;
      tick(2);
      sensor[1] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick(1);
         tests++;
         if (lv(1) !== 2'd3) begin
            fails++; $display("FAIL glitch_hold t=%0d: got %0d, want 3", t, lv(1));
         end
      end
      sensor[1] = 1'b0;
      tick(5);
      tests++;
      if (lv(1) !== 2'd3) begin
         fails++; $display("FAIL fall_early: got %0d, want 3", lv(1));
      end
      tick(1);
      tests++;
      if (lv(1) !== 2'd0 || any_alert !== 1'b0) begin
         fails++; $display("FAIL fall: got lvl %0d alert %b, want 0 0", lv(1), any_alert);
      end
   endtask

   task automatic test_simultaneous;
      int pulses;
      int pulse_t;
      int diff;
      pulses = 0; pulse_t = -1; diff = 0;
      sensor[0] = 1'b1;
      sensor[3] = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         tick(1);
         if (lv(0) !== lv(3)) diff++;
         if (alert_pulse === 1'b1) begin
            pulses++;
            pulse_t = t;
         end
         if (t == 24) begin
            tests++;
            if (lv(2) !== 2'd2) begin
               fails++; $display("FAIL sim_ch2_pre: got %0d, want 2", lv(2));
            end
         end
         if (t == 25) begin
            tests++;
            if (lv(2) !== 2'd3) begin
               fails++; $display("FAIL sim_ch2_l3: got %0d, want 3", lv(2));
            end
         end
         if (t == 3) sensor[2] = 1'b1;
      end
      tests++;
      if (diff !== 0) begin
         fails++; $display("FAIL sim_ch0_ch3_match: got %0d differing cycles, want 0", diff);
      end
      tests++;
      if (pulses !== 1 || pulse_t !== 22) begin
         fails++; $display("FAIL sim_single_pulse: got %0d pulses at t=%0d, want 1 at t=22", pulses, pulse_t);
      end
      tests++;
      if (lv(0) !== 2'd3 || any_alert !== 1'b1) begin
         fails++; $display("FAIL sim_final: got lvl %0d alert %b, want 3 1", lv(0), any_alert);
      end
   endtask

   task automatic test_enable;
      sensor = 4'b0000;
      tick(6);
      tests++;
      if (buzz_level !== 8'h00) begin
         fails++; $display("FAIL en_precond_clear: got %h, want 00", buzz_level);
      end
      sensor[0] = 1'b1;
      tick(14);
      tests++;
      if (lv(0) !== 2'd2) begin
         fails++; $display("FAIL en_precond_l2: got %0d, want 2", lv(0));
      end
      en = 1'b0;
      tick(1);
      tests++;
      if ({buzz_level, any_alert, alert_pulse} !== 10'b0) begin
         fails++; $display("FAIL en_off: got %b, want 0", {buzz_level, any_alert, alert_pulse});
      end
      tick(3);
      en = 1'b1;
      tick(3);
      tests++;
      if (lv(0) !== 2'd0) begin
         fails++; $display("FAIL en_restart_early: got %0d, want 0", lv(0));
      end
      tick(1);
      tests++;
      if (lv(0) !== 2'd1) begin
         fails++; $display("FAIL en_restart_l1: got %0d, want 1", lv(0));
      end
      tick(8);
      tests++;
      if (lv(0) !== 2'd2) begin
         fails++; $display("FAIL en_restart_l2: got %0d, want 2", lv(0));
      end
      tick(8);
      tests++;
      if (lv(0) !== 2'd3 || alert_pulse !== 1'b1) begin
         fails++; $display("FAIL en_restart_l3: got lvl %0d pulse %b, want 3 1", lv(0), alert_pulse);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      en = 1'b1;
      sensor = 4'b0000;
      test_reset();
      test_debounce();
      test_escalation();
      test_release_glitch();
      test_simultaneous();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
